// File: rtl/shader_loader.sv
// SPI-slave loader that streams a shader program into the shader instruction memory.
// Optional SPI readback of the displaced program is enabled by defining SHADER_LOADER_READBACK_EN.
module shader_loader #(
  parameter int          NUM_INSTR = 10,
  parameter logic [7:0]  CMD_LOAD  = 8'h01
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sclk_i,
  input  logic       spi_cs_ni,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  input  logic       exec_shift_i,
  input  logic [7:0] instr_mem_i,
  output logic       shift_o,
  output logic       load_o,
  output logic [7:0] instr_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;

  typedef enum logic [1:0] {IDLE, CMD, LOAD, IGNORE} state_t;

  state_t          state;
  logic            sclk_q1, sclk_q2, sclk_prev;
  logic            cs_q1, cs_q2, cs_prev;
  logic            sdi_q1, sdi_q2;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [CW-1:0]   word_cnt;
  logic            load_q, done_q;
  logic            sclk_rise, sclk_fall, cs_fall, byte_done;
  logic [7:0]      byte_val;

  // Synchronizer stage. cs_n resets low so a frame already in progress at
  // reset release never looks like a fresh CS falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q1 <= 1'b0; sclk_q2 <= 1'b0; sclk_prev <= 1'b0;
      cs_q1   <= 1'b0; cs_q2   <= 1'b0; cs_prev   <= 1'b0;
      sdi_q1  <= 1'b0; sdi_q2  <= 1'b0;
    end else begin
      sclk_q1 <= spi_sclk_i; sclk_q2 <= sclk_q1; sclk_prev <= sclk_q2;
      cs_q1   <= spi_cs_ni;  cs_q2   <= cs_q1;   cs_prev   <= cs_q2;
      sdi_q1  <= spi_sdi_i;  sdi_q2  <= sdi_q1;
    end
  end

  assign sclk_rise = sclk_q2 & ~sclk_prev;
  assign sclk_fall = ~sclk_q2 & sclk_prev;
  assign cs_fall   = ~cs_q2 & cs_prev;
  assign byte_val  = {shreg[6:0], sdi_q2};
  assign byte_done = sclk_rise & ~cs_q2 & (bit_cnt == 3'd7);

  // Deserializer stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (cs_q2) begin
      bit_cnt <= 3'd0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= byte_val;
    end
  end

  // Command/load stage; load_q and done_q are the one-cycle pulses that
  // follow a completed byte, issued even if CS has since deasserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      instr_o  <= 8'h00;
      word_cnt <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (cs_q2) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              word_cnt <= '0;
            end
          end
          CMD: begin
            if (byte_done) state <= (byte_val == CMD_LOAD) ? LOAD : IGNORE;
          end
          LOAD: begin
            if (byte_done) begin
              instr_o <= byte_val;
              load_q  <= 1'b1;
              if (word_cnt == CW'(NUM_INSTR - 1)) begin
                word_cnt <= '0;
                done_q   <= 1'b1;
              end else begin
                word_cnt <= word_cnt + CW'(1);
              end
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o  = (state == LOAD);
  assign load_o  = load_q;
  assign done_o  = done_q;
  assign shift_o = load_q | (~busy_o & exec_shift_i);

`ifdef SHADER_LOADER_READBACK_EN
  logic [7:0] rb_q;
  logic       sdo_q;

  // Readback stage: word leaving memory[0] is returned during the following byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_q  <= 8'h00;
      sdo_q <= 1'b0;
    end else begin
      if (cs_fall)     rb_q <= 8'h00;
      else if (load_q) rb_q <= instr_mem_i;
      if (state != LOAD) sdo_q <= 1'b0;
      else if (sclk_fall) sdo_q <= rb_q[~bit_cnt];
    end
  end

  assign spi_sdo_o = sdo_q;
`else
  logic unused_mem;
  assign unused_mem = ^instr_mem_i;
  assign spi_sdo_o  = 1'b0;
`endif

endmodule

// File: tb/tb_shader_loader.sv
// Directed testbench for shader_loader with a behavioural shader memory model.
module tb_shader_loader;
  localparam int NUM  = 10;
  localparam int HALF = 80;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       spi_sclk_i, spi_cs_ni, spi_sdi_i, spi_sdo_o;
  logic       exec_shift_i;
  logic [7:0] instr_mem_i;
  logic       shift_o, load_o, busy_o, done_o;
  logic [7:0] instr_o;

  shader_loader #(.NUM_INSTR(NUM), .CMD_LOAD(8'h01)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .spi_sclk_i(spi_sclk_i), .spi_cs_ni(spi_cs_ni), .spi_sdi_i(spi_sdi_i),
    .spi_sdo_o(spi_sdo_o), .exec_shift_i(exec_shift_i), .instr_mem_i(instr_mem_i),
    .shift_o(shift_o), .load_o(load_o), .instr_o(instr_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Shader memory model: shift+load pushes instr_o at the tail, shift alone rotates.
  logic [7:0] mem [NUM];
  assign instr_mem_i = mem[0];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM; i++) mem[i] <= 8'h00;
    end else if (shift_o) begin
      for (int i = 0; i < NUM - 1; i++) mem[i] <= mem[i+1];
      mem[NUM-1] <= load_o ? instr_o : mem[0];
    end
  end

  // Pulse monitor
  logic [7:0] loaded[$];
  int n_done = 0, done_idx = -1, bad_shift = 0, long_pulse = 0;
  logic load_prev = 1'b0;
  always @(negedge clk_i) begin
    if (load_o) loaded.push_back(instr_o);
    if (done_o) begin n_done++; done_idx = loaded.size(); end
    if (busy_o && (shift_o !== load_o)) bad_shift++;
    if (load_o && !shift_o) bad_shift++;
    if (load_o && load_prev) long_pulse++;
    load_prev = load_o;
  end

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] rd);
    for (int i = 7; i >= 0; i--) begin
      spi_sdi_i = b[i];
      #(HALF);
      rd[i] = spi_sdo_o;
      spi_sclk_i = 1'b1;
      #(HALF);
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_sdi_i = b[i];
      #(HALF); spi_sclk_i = 1'b1;
      #(HALF); spi_sclk_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_ni = 1'b0;
    #200;
  endtask

  task automatic cs_high();
    #(HALF);
    spi_cs_ni = 1'b1;
    #300;
  endtask

  logic [7:0] prog [NUM] = '{8'h10, 8'h15, 8'h74, 8'h00, 8'h40, 8'h3C, 8'h99, 8'hA5, 8'hFF, 8'h01};
  logic [7:0] rd;
  logic [7:0] rb [NUM+1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; spi_cs_ni = 1'b1; spi_sclk_i = 1'b0; spi_sdi_i = 1'b0; exec_shift_i = 1'b0;
    #23;
    check("rst_shift", shift_o, 0);
    check("rst_load", load_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sdo", spi_sdo_o, 0);
    rst_ni = 1'b1;
    #50;

    // Full program with exec_shift_i held high during the frame
    loaded.delete(); n_done = 0; done_idx = -1; bad_shift = 0; long_pulse = 0;
    exec_shift_i = 1'b1;
    cs_low();
    spi_byte(8'h01, rd);
    check("busy_after_cmd", busy_o, 1);
    check("exec_blocked", shift_o, 0);
    for (int i = 0; i < NUM; i++) spi_byte(prog[i], rd);
    check("busy_before_cs", busy_o, 1);
    cs_high();
    exec_shift_i = 1'b0;
    check("busy_after_cs", busy_o, 0);
    check("load_count", loaded.size(), NUM);
    for (int i = 0; i < NUM && i < loaded.size(); i++) check($sformatf("instr_%0d", i), loaded[i], prog[i]);
    check("done_count", n_done, 1);
    check("done_on_10th", done_idx, NUM);
    check("shift_only_on_load", bad_shift, 0);
    check("pulse_width", long_pulse, 0);

    // Non-load command: bytes ignored, exec shift passes through
    loaded.delete();
    cs_low();
    spi_byte(8'h5A, rd);
    exec_shift_i = 1'b1; #2;
    check("pass_exec_hi", shift_o, 1);
    exec_shift_i = 1'b0; #2;
    check("pass_exec_lo", shift_o, 0);
    check("ignore_busy", busy_o, 0);
    spi_byte(8'h11, rd); spi_byte(8'h22, rd); spi_byte(8'h33, rd);
    cs_high();
    check("ignore_loads", loaded.size(), 0);

    // Abort mid-byte, then a fresh frame
    loaded.delete();
    cs_low();
    spi_byte(8'h01, rd); spi_byte(8'h21, rd); spi_byte(8'h22, rd);
    spi_bits(8'h23, 4);
    cs_high();
    check("abort_loads", loaded.size(), 2);
    if (loaded.size() >= 2) begin
      check("abort_b0", loaded[0], 8'h21);
      check("abort_b1", loaded[1], 8'h22);
    end
    check("abort_idle", busy_o, 0);
    cs_low();
    spi_byte(8'h01, rd); spi_byte(8'hAB, rd);
    cs_high();
    check("reload_count", loaded.size(), 3);
    if (loaded.size() >= 3) check("reload_ab", loaded[2], 8'hAB);

    // Reset mid-frame with CS held low
    cs_low();
    spi_byte(8'h01, rd);
    for (int i = 0; i < 5; i++) spi_byte(8'h50 + 8'(i), rd);
    #20;
    rst_ni = 1'b0;
    #2;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_instr", instr_o, 0);
    check("mid_rst_load", load_o, 0);
    check("mid_rst_shift", shift_o, 0);
    check("mid_rst_done", done_o, 0);
    #30;
    rst_ni = 1'b1;
    #40;
    loaded.delete();
    spi_byte(8'h01, rd); spi_byte(8'h77, rd);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_loads", loaded.size(), 0);
    cs_high();
    cs_low();
    spi_byte(8'h01, rd); spi_byte(8'h66, rd);
    cs_high();
    check("post_rst_new", loaded.size(), 1);
    if (loaded.size() >= 1) check("post_rst_66", loaded[0], 8'h66);

    // Readback: load default program, then read it back while loading 11 bytes
    cs_low();
    spi_byte(8'h01, rd);
    for (int i = 0; i < NUM; i++) spi_byte(prog[i], rd);
    cs_high();
    cs_low();
    spi_byte(8'h01, rd);
    check("rb_cmd_sdo", rd, 8'h00);
    for (int i = 0; i <= NUM; i++) begin
      spi_byte(8'hC0 + 8'(i), rd);
      rb[i] = rd;
    end
    cs_high();
`ifdef SHADER_LOADER_READBACK_EN
    check("rb_first", rb[0], 8'h00);
    for (int i = 1; i <= NUM; i++) check($sformatf("rb_%0d", i), rb[i], prog[i-1]);
`else
    for (int i = 0; i <= NUM; i++) check($sformatf("sdo_tied_%0d", i), rb[i], 8'h00);
`endif
    check("rb_idle_sdo", spi_sdo_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
